cond_fetch_sequencer: RTL
=========================

Name: cond_fetch_sequencer

Overview:
Parametrised fetch/decode/condition sequencer for the ARM-style datapath. It drives the MAR, IR, memory enable and read/write strobes, and waits on the memory MFC handshake. It evaluates the full ARM condition-code set against the NZCV flags, then either hands the instruction to the execute stage through a start/done handshake or skips it. It also keeps a saturating count of skipped instructions.

Parameters:
DATA_W, 32, width of instruction and status_reg; flags at bits DATA_W-1..DATA_W-4 = N,Z,C,V
WAIT_MAX, 15, max MEM_WAIT cycles before timeout (only with MFC_TIMEOUT_EN); >=1
SKIP_W, 8, width of skip_cnt
NV_EXEC, 0, 1 = cond 4'b1111 executes; 0 = cond 4'b1111 always fails

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  reset, asynchronous, active-low
instruction  in  DATA_W  IR contents; cond = instruction[DATA_W-1:DATA_W-4]
status_reg  in  DATA_W  status register; N,Z,C,V in top 4 bits
mfc  in  1  memory function complete
exec_done  in  1  execute stage finished
reg_clr  out  1  register-file clear
mar_en  out  1  MAR load
ir_en  out  1  IR load
mem_en  out  1  memory enable
mem_rw  out  1  1 = read, 0 = write/idle
pc_inc  out  1  one-cycle PC advance strobe
exec_start  out  1  one-cycle execute start
cond_pass  out  1  registered result of last condition check
skip_cnt  out  SKIP_W  number of failed-condition instructions, saturating
fetch_err  out  1  memory timeout flag (sticky)

Behaviour:
- States: RST(0), FETCH(1), MEMW(2), DECODE(3), EXEC(4), EXWAIT(5), ERR(6). Encoding is 3 bits. Unused codes return to RST.
- clr low: state=RST; skip_cnt=0; cond_pass=0; fetch_err=0; wait counter=0.
- Outputs are Moore, decoded from state:
  - RST: reg_clr=1; all other outputs 0.
  - FETCH: mar_en=1.
  - MEMW: mem_en=1, mem_rw=1, ir_en=1.
  - DECODE: pc_inc=1.
  - EXEC: exec_start=1.
  - EXWAIT, ERR: all strobes 0.
- Transitions:
  - RST -> FETCH after 1 cycle with clr high.
  - FETCH -> MEMW after 1 cycle.
  - MEMW: holds while mfc=0. mfc=1 sampled -> DECODE. IR captures in the mfc cycle. Minimum MEMW dwell is 1 cycle.
  - DECODE: condition pass -> EXEC, cond_pass<=1. Condition fail -> FETCH, cond_pass<=0, skip_cnt increments unless it is all-ones.
  - EXEC: exec_done=1 in the same cycle -> FETCH. Otherwise -> EXWAIT.
  - EXWAIT: holds until exec_done=1, then -> FETCH.
  - exec_done outside EXEC/EXWAIT is ignored.
- Condition table (N,Z,C,V from status_reg, sampled in DECODE):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: NV_EXEC
- Latency:
  - Fetch-to-decode = 2 + (MEMW cycles).
  - Skipped instruction costs 1 DECODE cycle.
  - Executed instruction adds EXEC plus EXWAIT cycles.
- clr asserted in any state, including mid-MEMW or EXWAIT, forces RST immediately. The pending fetch or execute is abandoned and no exec_start is issued.

Optional Feature:
- Macro: MFC_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to MEMW and increments each MEMW cycle with mfc=0.
  - When it reaches WAIT_MAX with mfc still 0 -> ERR, fetch_err<=1.
  - ERR holds until clr. mfc in ERR is ignored.
  - mfc=1 in the same cycle the counter reaches WAIT_MAX wins: next state is DECODE.
- Undefined: no counter and no ERR path; MEMW waits indefinitely; fetch_err is constant 0.

Test Plan:
- clr low 3 cycles, then high -> reg_clr=1 for exactly 1 cycle after release; next cycle mar_en=1; skip_cnt=0.
- instruction=0xE0000000 (AL), mfc high on the 3rd MEMW cycle -> DECODE with pc_inc=1, then exec_start pulse 1 cycle; exec_done after 2 cycles -> back to FETCH; cond_pass=1.
- instruction=0x0xxxxxxx (EQ), Z=0 -> DECODE -> FETCH, no exec_start, skip_cnt 0->1. Repeat with Z=1 -> exec_start pulses.
- GT/LE sweep over all 16 NZCV values -> GT passes only for Z=0 with N==V; LE is its exact complement. Cond 0xF with NV_EXEC=0 never passes.
- SKIP_W=2, five consecutive failed conditions -> skip_cnt reads 1,2,3,3,3 (saturation at 3).
- MFC_TIMEOUT_EN, WAIT_MAX=4, mfc never asserted -> ERR and fetch_err=1 after 4 MEMW cycles, held; pulse clr -> fetch_err=0, RST. Also assert clr mid-EXWAIT -> RST with no further exec_start.

Source files
------------

// File: rtl/cond_fetch_sequencer.sv
// cond_fetch_sequencer: ARM-style fetch/decode/condition sequencer with saturating skip counter.
// Define MFC_TIMEOUT_EN to add the MEMW timeout path into the sticky ERR state.
module cond_fetch_sequencer #(
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 15,
    parameter int SKIP_W   = 8,
    parameter int NV_EXEC  = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] status_reg,
    input  logic              mfc,
    input  logic              exec_done,
    output logic              reg_clr,
    output logic              mar_en,
    output logic              ir_en,
    output logic              mem_en,
    output logic              mem_rw,
    output logic              pc_inc,
    output logic              exec_start,
    output logic              cond_pass,
    output logic [SKIP_W-1:0] skip_cnt,
    output logic              fetch_err
);
    typedef enum logic [2:0] {RST, FETCH, MEMW, DECODE, EXEC, EXWAIT, ERR} state_t;
    state_t state, next;
    logic n, z, c, v, pass;
    logic [3:0] cond;
    logic [15:0] tbl;
    logic unused_bits;
    assign {n, z, c, v} = status_reg[DATA_W-1 -: 4];
    assign cond = instruction[DATA_W-1 -: 4];
    assign unused_bits = ^{instruction[DATA_W-5:0], status_reg[DATA_W-5:0]};
    // one pass bit per condition code, indexed by cond (bit 0 = EQ ... bit 15 = NV)
    assign tbl = {NV_EXEC != 0, 1'b1, z | (n != v), !z & (n == v), n != v, n == v,
                  !c | z, c & !z, !v, v, !n, n, !c, c, !z, z};
    assign pass = tbl[cond];
`ifdef MFC_TIMEOUT_EN
    localparam int WW = $clog2(WAIT_MAX + 1);
    logic [WW-1:0] wcnt;
    logic timeout;
    assign timeout = wcnt == WW'(WAIT_MAX - 1);
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wcnt      <= '0;
            fetch_err <= 1'b0;
        end else begin
            wcnt      <= state == FETCH ? '0 : (state == MEMW && !mfc) ? wcnt + 1'b1 : wcnt;
            fetch_err <= fetch_err | (state == MEMW && next == ERR);
        end
    end
`else
    logic timeout;
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= RST;
        else      state <= next;
    end
    always_comb begin
        next = RST;
        case (state)
            RST:    next = FETCH;
            FETCH:  next = MEMW;
            MEMW:   next = mfc ? DECODE : timeout ? ERR : MEMW;
            DECODE: next = pass ? EXEC : FETCH;
            EXEC:   next = exec_done ? FETCH : EXWAIT;
            EXWAIT: next = exec_done ? FETCH : EXWAIT;
            ERR:    next = ERR;
            default: next = RST;
        endcase
    end
    always_comb begin
        reg_clr    = state == RST;
        mar_en     = state == FETCH;
        mem_en     = state == MEMW;
        mem_rw     = state == MEMW;
        ir_en      = state == MEMW;
        pc_inc     = state == DECODE;
        exec_start = state == EXEC;
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cond_pass <= 1'b0;
            skip_cnt  <= '0;
        end else if (state == DECODE) begin
            cond_pass <= pass;
            if (!pass && skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
        end
    end
endmodule
